wb_arbiter2: RTL and testbench

Two-master Wishbone classic arbiter that shares the SoC slave path (address decoder/mux feeding RAM, timer, UART) between the CPU and the external debug/transaction master. It replaces the static master select with cycle-level arbitration. Grant is held for a whole `cyc` and tracked with a per-transaction bus watchdog. It sits between `cpu0`/`ext0` and the slave-side mux.

---
 rtl/wb_arbiter2.sv | 234 +++++++++++++++++++++++
 tb/tb_wb_arbiter2.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter2.sv
`default_nettype none
//============================================================================
// Module      : wb_arbiter2
// Description : Two-master Wishbone classic arbiter. Grants the shared slave
//               path for a whole cyc, arbitrates fixed-priority or
//               round-robin, and aborts a stalled access with a per-transfer
//               no-ack watchdog that returns TIMEOUT_DATA to the owner.
// Revision    : 1.0 - initial release
//============================================================================
module wb_arbiter2 #(
    parameter int                       WB_DATA_WIDTH  = 32,
    parameter int                       WB_ADDR_WIDTH  = 32,
    parameter int                       WB_SEL_WIDTH   = 4,
    parameter int                       ARB_MODE       = 1,
    parameter int                       TIMEOUT_CYCLES = 255,
    parameter logic [WB_DATA_WIDTH-1:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    // master 0 (CPU)
    input  logic [WB_ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [WB_DATA_WIDTH-1:0] m0_data_i,
    input  logic [WB_SEL_WIDTH-1:0]  m0_sel_i,
    input  logic                     m0_we_i,
    input  logic                     m0_stb_i,
    input  logic                     m0_cyc_i,
    output logic                     m0_ack_o,
    output logic [WB_DATA_WIDTH-1:0] m0_data_o,
    // master 1 (external)
    input  logic [WB_ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [WB_DATA_WIDTH-1:0] m1_data_i,
    input  logic [WB_SEL_WIDTH-1:0]  m1_sel_i,
    input  logic                     m1_we_i,
    input  logic                     m1_stb_i,
    input  logic                     m1_cyc_i,
    output logic                     m1_ack_o,
    output logic [WB_DATA_WIDTH-1:0] m1_data_o,
    // slave side
    output logic [WB_ADDR_WIDTH-1:0] s_addr_o,
    output logic [WB_DATA_WIDTH-1:0] s_data_o,
    output logic [WB_SEL_WIDTH-1:0]  s_sel_o,
    output logic                     s_we_o,
    output logic                     s_stb_o,
    output logic                     s_cyc_o,
    input  logic                     s_ack_i,
    input  logic [WB_DATA_WIDTH-1:0] s_data_i,
    // status
    output logic [1:0]               grant_o,
    output logic                     timeout_o,
    input  logic                     timeout_clear_i
);

    localparam logic [1:0]  c_st_idle  = 2'd0;
    localparam logic [1:0]  c_st_own0  = 2'd1;
    localparam logic [1:0]  c_st_own1  = 2'd2;
    localparam logic [1:0]  c_st_abort = 2'd3;

    // Last count value at which a still-unacked strobe expires.
    localparam logic [15:0] c_wd_limit = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0]  r_state;
    logic        r_last_grant;
    logic [15:0] r_wd_cnt;
    logic        r_abort_owner;
    logic        r_timeout;

    logic [1:0]  w_state_nxt;
    logic        w_last_grant_nxt;
    logic        w_abort_owner_nxt;
    logic [15:0] w_wd_cnt_nxt;
    logic        w_tie_pick;
    logic        w_noack;
    logic        w_wd_expire;

    // Which master takes a simultaneous request (1 = m1).
    generate
        if (ARB_MODE == 0) begin : g_fixed_prio
            assign w_tie_pick = 1'b1;
        end else begin : g_round_robin
            assign w_tie_pick = ~r_last_grant;
        end
    endgenerate

    // Owner strobing without an ack this cycle; the watchdog counts these.
    always_comb begin
        w_noack = 1'b0;
        case (r_state)
            c_st_own0: w_noack = m0_stb_i & ~s_ack_i;
            c_st_own1: w_noack = m1_stb_i & ~s_ack_i;
            default:   w_noack = 1'b0;
        endcase
    end

    assign w_wd_expire = w_noack && (r_wd_cnt == c_wd_limit);

    // Next-state, owner-history and abort-owner selection.
    always_comb begin
        w_state_nxt       = r_state;
        w_last_grant_nxt  = r_last_grant;
        w_abort_owner_nxt = r_abort_owner;
        case (r_state)
            c_st_idle: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    w_state_nxt      = w_tie_pick ? c_st_own1 : c_st_own0;
                    w_last_grant_nxt = w_tie_pick;
                end else if (m0_cyc_i) begin
                    w_state_nxt      = c_st_own0;
                    w_last_grant_nxt = 1'b0;
                end else if (m1_cyc_i) begin
                    w_state_nxt      = c_st_own1;
                    w_last_grant_nxt = 1'b1;
                end
            end
            c_st_own0: begin
                if (!m0_cyc_i) begin
                    w_state_nxt = c_st_idle;
                end else if (w_wd_expire) begin
                    w_state_nxt       = c_st_abort;
                    w_abort_owner_nxt = 1'b0;
                end
            end
            c_st_own1: begin
                if (!m1_cyc_i) begin
                    w_state_nxt = c_st_idle;
                end else if (w_wd_expire) begin
                    w_state_nxt       = c_st_abort;
                    w_abort_owner_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // Watchdog restarts on any ack, idle strobe or ownership change.
    always_comb begin
        w_wd_cnt_nxt = 16'd0;
        if ((w_state_nxt == r_state) && w_noack) begin
            w_wd_cnt_nxt = r_wd_cnt + 16'd1;
        end
    end

    // State, arbitration history and watchdog registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= c_st_idle;
            r_last_grant  <= 1'b1;
            r_wd_cnt      <= 16'd0;
            r_abort_owner <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_last_grant  <= w_last_grant_nxt;
            r_wd_cnt      <= w_wd_cnt_nxt;
            r_abort_owner <= w_abort_owner_nxt;
        end
    end

    // Sticky timeout flag; a set in the same cycle as a clear takes priority.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_timeout <= 1'b0;
        end else if (r_state == c_st_abort) begin
            r_timeout <= 1'b1;
        end else if (timeout_clear_i) begin
            r_timeout <= 1'b0;
        end
    end

    // Combinational request/response steering for the current owner.
    always_comb begin
        s_addr_o  = '0;
        s_data_o  = '0;
        s_sel_o   = '0;
        s_we_o    = 1'b0;
        s_stb_o   = 1'b0;
        s_cyc_o   = 1'b0;
        m0_ack_o  = 1'b0;
        m0_data_o = '0;
        m1_ack_o  = 1'b0;
        m1_data_o = '0;
        case (r_state)
            c_st_own0: begin
                s_addr_o  = m0_addr_i;
                s_data_o  = m0_data_i;
                s_sel_o   = m0_sel_i;
                s_we_o    = m0_we_i;
                s_stb_o   = m0_stb_i;
                s_cyc_o   = m0_cyc_i;
                m0_ack_o  = s_ack_i;
                m0_data_o = s_data_i;
            end
            c_st_own1: begin
                s_addr_o  = m1_addr_i;
                s_data_o  = m1_data_i;
                s_sel_o   = m1_sel_i;
                s_we_o    = m1_we_i;
                s_stb_o   = m1_stb_i;
                s_cyc_o   = m1_cyc_i;
                m1_ack_o  = s_ack_i;
                m1_data_o = s_data_i;
            end
            c_st_abort: begin
                // Slave side stays released; the stalled owner gets a
                // synthetic ack carrying the timeout pattern.
                if (r_abort_owner) begin
                    m1_ack_o  = 1'b1;
                    m1_data_o = TIMEOUT_DATA;
                end else begin
                    m0_ack_o  = 1'b1;
                    m0_data_o = TIMEOUT_DATA;
                end
            end
            default: begin
                s_cyc_o = 1'b0;
            end
        endcase
    end

    // Owner decode of the registered state; the aborted owner stays visible.
    always_comb begin
        grant_o = 2'b00;
        case (r_state)
            c_st_own0:  grant_o = 2'b01;
            c_st_own1:  grant_o = 2'b10;
            c_st_abort: grant_o = r_abort_owner ? 2'b10 : 2'b01;
            default:    grant_o = 2'b00;
        endcase
    end

    assign timeout_o = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter2.sv
`default_nettype none
//============================================================================
// Module      : tb_wb_arbiter2
// Description : Self-checking bench for wb_arbiter2 (round-robin and
//               fixed-priority instances, watchdog, reset mid-transfer).
// Revision    : 1.0 - initial release
//============================================================================
module tb_wb_arbiter2;

    localparam logic [31:0] c_dead_addr = 32'hFFFF_0000;
    localparam logic [31:0] c_to_data   = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, tclr;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_sel, m1_sel;
    logic        m0_we, m0_stb, m0_cyc, m1_we, m1_stb, m1_cyc;

    // slave responder control
    logic        manual, man_ack;
    logic [31:0] man_data;
    int unsigned lat = 1;

    // instance A: round-robin
    logic        a_m0_ack, a_m1_ack, a_s_we, a_s_stb, a_s_cyc, a_s_ack, a_timeout;
    logic [31:0] a_m0_rdata, a_m1_rdata, a_s_addr, a_s_wdata, a_s_rdata;
    logic [3:0]  a_s_sel;
    logic [1:0]  a_grant;
    int unsigned a_wait = 0;
    // instance B: fixed priority
    logic        b_m0_ack, b_m1_ack, b_s_we, b_s_stb, b_s_cyc, b_s_ack, b_timeout;
    logic [31:0] b_m0_rdata, b_m1_rdata, b_s_addr, b_s_wdata, b_s_rdata;
    logic [3:0]  b_s_sel;
    logic [1:0]  b_grant;
    int unsigned b_wait = 0;

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        return a ^ 32'h5A5A_1234;
    endfunction

    // Slave: acks after 'lat' waited cycles, never acks the dead address.
    assign a_s_ack   = manual ? man_ack : (a_s_stb && (a_s_addr != c_dead_addr) && (a_wait == lat));
    assign a_s_rdata = manual ? man_data : ram_word(a_s_addr);
    assign b_s_ack   = manual ? man_ack : (b_s_stb && (b_s_addr != c_dead_addr) && (b_wait == lat));
    assign b_s_rdata = manual ? man_data : ram_word(b_s_addr);
    always_ff @(posedge clk) a_wait <= (a_s_stb && !a_s_ack) ? a_wait + 1 : 0;
    always_ff @(posedge clk) b_wait <= (b_s_stb && !b_s_ack) ? b_wait + 1 : 0;

    wb_arbiter2 #(.ARB_MODE(1), .TIMEOUT_CYCLES(8)) dut_a (
        .clk_i(clk), .rst_i(rst),
        .m0_addr_i(m0_addr), .m0_data_i(m0_wdata), .m0_sel_i(m0_sel), .m0_we_i(m0_we),
        .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc), .m0_ack_o(a_m0_ack), .m0_data_o(a_m0_rdata),
        .m1_addr_i(m1_addr), .m1_data_i(m1_wdata), .m1_sel_i(m1_sel), .m1_we_i(m1_we),
        .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc), .m1_ack_o(a_m1_ack), .m1_data_o(a_m1_rdata),
        .s_addr_o(a_s_addr), .s_data_o(a_s_wdata), .s_sel_o(a_s_sel), .s_we_o(a_s_we),
        .s_stb_o(a_s_stb), .s_cyc_o(a_s_cyc), .s_ack_i(a_s_ack), .s_data_i(a_s_rdata),
        .grant_o(a_grant), .timeout_o(a_timeout), .timeout_clear_i(tclr)
    );

    wb_arbiter2 #(.ARB_MODE(0), .TIMEOUT_CYCLES(8)) dut_b (
        .clk_i(clk), .rst_i(rst),
        .m0_addr_i(m0_addr), .m0_data_i(m0_wdata), .m0_sel_i(m0_sel), .m0_we_i(m0_we),
        .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc), .m0_ack_o(b_m0_ack), .m0_data_o(b_m0_rdata),
        .m1_addr_i(m1_addr), .m1_data_i(m1_wdata), .m1_sel_i(m1_sel), .m1_we_i(m1_we),
        .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc), .m1_ack_o(b_m1_ack), .m1_data_o(b_m1_rdata),
        .s_addr_o(b_s_addr), .s_data_o(b_s_wdata), .s_sel_o(b_s_sel), .s_we_o(b_s_we),
        .s_stb_o(b_s_stb), .s_cyc_o(b_s_cyc), .s_ack_i(b_s_ack), .s_data_i(b_s_rdata),
        .grant_o(b_grant), .timeout_o(b_timeout), .timeout_clear_i(tclr)
    );

    // View of whichever instance the reactive masters follow.
    logic        sel_b = 1'b0;
    logic        v_m0_ack, v_m1_ack;
    logic [31:0] v_m0_rdata, v_m1_rdata;
    logic [1:0]  v_grant;
    assign v_m0_ack   = sel_b ? b_m0_ack   : a_m0_ack;
    assign v_m1_ack   = sel_b ? b_m1_ack   : a_m1_ack;
    assign v_m0_rdata = sel_b ? b_m0_rdata : a_m0_rdata;
    assign v_m1_rdata = sel_b ? b_m1_rdata : a_m1_rdata;
    assign v_grant    = sel_b ? b_grant    : a_grant;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic to_sample();
        @(negedge clk);
    endtask

    // ---------------- forwarding vectors ----------------
    typedef struct {
        logic        stb, we;
        logic [31:0] addr, wdata;
        logic [3:0]  sel;
        logic        m1cyc, ack;
        logic [31:0] rdata;
        logic        e_stb, e_we;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_sel;
        logic        e_ack;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs[7];

    function automatic vec_t mk(input logic stb, we, input logic [31:0] addr, wdata,
                                input logic [3:0] sel, input logic m1c, ack,
                                input logic [31:0] rd, input logic es, ew,
                                input logic [31:0] ea, ewd, input logic [3:0] esel,
                                input logic eack, input logic [31:0] ed);
        vec_t v;
        v.stb = stb; v.we = we; v.addr = addr; v.wdata = wdata; v.sel = sel;
        v.m1cyc = m1c; v.ack = ack; v.rdata = rd;
        v.e_stb = es; v.e_we = ew; v.e_addr = ea; v.e_wdata = ewd; v.e_sel = esel;
        v.e_ack = eack; v.e_data = ed;
        return v;
    endfunction

    // ---------------- reactive masters + scoreboard ----------------
    int mst_mode[2];   // 0 off, 1 requesting, 2 one-cycle cyc drop
    int bursts[2];
    int txn_left[2];
    int seq[2];
    logic [31:0] q0[$];
    logic [31:0] q1[$];

    function automatic logic [31:0] mst_addr(input int m);
        return (m == 0 ? 32'h0000_1000 : 32'h0000_8000) + 32'(seq[m] * 4);
    endfunction

    task automatic start_txn(input int m);
        if (m == 0) q0.push_back(ram_word(mst_addr(0)));
        else        q1.push_back(ram_word(mst_addr(1)));
    endtask

    task automatic master_drive();
        m0_cyc = (mst_mode[0] == 1); m0_stb = (mst_mode[0] == 1);
        m0_we = 1'b0; m0_sel = 4'hF; m0_addr = mst_addr(0); m0_wdata = '0;
        m1_cyc = (mst_mode[1] == 1); m1_stb = (mst_mode[1] == 1);
        m1_we = 1'b0; m1_sel = 4'hF; m1_addr = mst_addr(1); m1_wdata = '0;
    endtask

    task automatic master_update(input string tag);
        logic        ack;
        logic [31:0] data, exp;
        for (int m = 0; m < 2; m++) begin
            ack  = (m == 0) ? v_m0_ack : v_m1_ack;
            data = (m == 0) ? v_m0_rdata : v_m1_rdata;
            if (ack) begin
                if (mst_mode[m] != 1 || (m == 0 ? q0.size() : q1.size()) == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL %s unexpected ack m%0d: got ack 1, expected 0", tag, m);
                end else begin
                    exp = (m == 0) ? q0.pop_front() : q1.pop_front();
                    chk($sformatf("%s m%0d read data", tag, m), data, exp);
                    seq[m]++;
                    txn_left[m]--;
                    if (txn_left[m] == 0) begin
                        mst_mode[m] = 2;
                        bursts[m]--;
                    end else begin
                        start_txn(m);
                    end
                end
            end else if (mst_mode[m] == 2) begin
                if (bursts[m] > 0) begin
                    mst_mode[m] = 1; txn_left[m] = 3; start_txn(m);
                end else begin
                    mst_mode[m] = 0;
                end
            end
        end
    endtask

    task automatic idle_inputs();
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0; m0_sel = '0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_sel = '0;
        tclr = 0;
    endtask

    // Enter and leave at a drive point; state is IDLE afterwards.
    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        to_drive();
        to_drive();
        rst = 1'b0;
    endtask

    // Runs both masters (b0/b1 bursts of 3 reads) and checks owner order
    // (2 bits per entry, first entry in the low bits) and one-cycle gaps.
    task automatic run_masters(input logic use_b, input int b0, input int b1,
                               input logic [7:0] exp_order, input int n_exp,
                               input string tag);
        int         n_own = 0;
        int         zero_run = 0;
        logic [1:0] prev = 2'b00;
        logic [1:0] g;
        logic       done = 1'b0;
        do_reset();
        sel_b = use_b; manual = 1'b0; lat = 1;
        for (int m = 0; m < 2; m++) begin
            seq[m] = 0; txn_left[m] = 3;
            bursts[m]   = (m == 0) ? b0 : b1;
            mst_mode[m] = (bursts[m] > 0) ? 1 : 0;
            if (bursts[m] > 0) start_txn(m);
        end
        master_drive();
        for (int c = 0; c < 200; c++) begin
            to_sample();
            g = v_grant;
            if (g == 2'b00) begin
                zero_run++;
            end else if (prev == 2'b00) begin
                if (n_own < n_exp) begin
                    chk($sformatf("%s owner %0d", tag, n_own), 32'(g), 32'(exp_order[2*n_own +: 2]));
                end else begin
                    n_checks++; n_errors++;
                    $display("FAIL %s extra owner: got 0x%0h, expected none", tag, g);
                end
                if (n_own > 0) chk($sformatf("%s idle gap %0d", tag, n_own), zero_run, 1);
                n_own++;
                zero_run = 0;
            end
            prev = g;
            master_update(tag);
            to_drive();
            master_drive();
            if (mst_mode[0] == 0 && mst_mode[1] == 0) begin
                done = 1'b1;
                break;
            end
        end
        chk({tag, " completed in budget"}, 32'(done), 1);
        chk({tag, " owner count"}, n_own, n_exp);
        chk({tag, " queues drained"}, q0.size() + q1.size(), 0);
        q0.delete();
        q1.delete();
        sel_b = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global time limit: got no finish, expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        int          ack_k;
        int          n_ack;
        logic [31:0] exp;

        vecs[0] = mk(1, 0, 32'h1000, 32'h0, 4'hF, 0, 0, 32'h1111_2222,
                     1, 0, 32'h1000, 32'h0, 4'hF, 0, 32'h1111_2222);
        vecs[1] = mk(1, 0, 32'h1000, 32'h0, 4'hF, 0, 1, 32'hCAFE_0001,
                     1, 0, 32'h1000, 32'h0, 4'hF, 1, 32'hCAFE_0001);
        vecs[2] = mk(0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 32'h0,
                     0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0);
        vecs[3] = mk(1, 1, 32'h2004, 32'h1234_5678, 4'h3, 1, 0, 32'h0,
                     1, 1, 32'h2004, 32'h1234_5678, 4'h3, 0, 32'h0);
        vecs[4] = mk(1, 1, 32'h2004, 32'h1234_5678, 4'h3, 1, 1, 32'h0,
                     1, 1, 32'h2004, 32'h1234_5678, 4'h3, 1, 32'h0);
        vecs[5] = mk(1, 0, 32'h3008, 32'h0, 4'hC, 1, 0, 32'h55AA_55AA,
                     1, 0, 32'h3008, 32'h0, 4'hC, 0, 32'h55AA_55AA);
        vecs[6] = mk(1, 0, 32'h3008, 32'h0, 4'hC, 1, 1, 32'h55AA_55AA,
                     1, 0, 32'h3008, 32'h0, 4'hC, 1, 32'h55AA_55AA);

        // ---- reset state ----
        idle_inputs();
        rst = 1'b1; manual = 1'b1; man_ack = 1'b0; man_data = 32'h0;
        to_drive();
        to_drive();
        to_sample();
        chk("reset s_cyc", a_s_cyc, 0);
        chk("reset s_stb", a_s_stb, 0);
        chk("reset s_addr", a_s_addr, 0);
        chk("reset grant", a_grant, 0);
        chk("reset grant B", b_grant, 0);
        chk("reset timeout", a_timeout, 0);
        chk("reset m0_ack", a_m0_ack, 0);
        chk("reset m1_data", a_m1_rdata, 0);

        // ---- single master, grant latency ----
        to_drive();
        rst = 1'b0;
        m0_cyc = 1; m0_stb = 1; m0_addr = 32'h1000; m0_sel = 4'hF; m0_we = 0;
        man_data = 32'h1111_2222;
        to_sample();
        chk("latency s_cyc before grant", a_s_cyc, 0);
        chk("latency grant before grant", a_grant, 0);

        // ---- forwarding vectors with m0 as owner ----
        m1_addr = 32'h0000_BAD0; m1_we = 1; m1_wdata = 32'hFFFF_FFFF; m1_sel = 4'h1;
        for (int i = 0; i < 7; i++) begin
            to_drive();
            m0_stb = vecs[i].stb; m0_we = vecs[i].we; m0_addr = vecs[i].addr;
            m0_wdata = vecs[i].wdata; m0_sel = vecs[i].sel;
            m1_cyc = vecs[i].m1cyc; m1_stb = vecs[i].m1cyc;
            man_ack = vecs[i].ack; man_data = vecs[i].rdata;
            to_sample();
            chk($sformatf("vec%0d s_cyc", i), a_s_cyc, 1);
            chk($sformatf("vec%0d s_stb", i), a_s_stb, vecs[i].e_stb);
            chk($sformatf("vec%0d s_we", i), a_s_we, vecs[i].e_we);
            chk($sformatf("vec%0d s_addr", i), a_s_addr, vecs[i].e_addr);
            chk($sformatf("vec%0d s_data", i), a_s_wdata, vecs[i].e_wdata);
            chk($sformatf("vec%0d s_sel", i), a_s_sel, vecs[i].e_sel);
            chk($sformatf("vec%0d m0_ack", i), a_m0_ack, vecs[i].e_ack);
            chk($sformatf("vec%0d m0_data", i), a_m0_rdata, vecs[i].e_data);
            chk($sformatf("vec%0d m1_ack", i), a_m1_ack, 0);
            chk($sformatf("vec%0d m1_data", i), a_m1_rdata, 0);
            chk($sformatf("vec%0d grant", i), a_grant, 2'b01);
        end

        // ---- handoff m0 -> m1 ----
        to_drive();
        m0_cyc = 0; m0_stb = 0; man_ack = 0;
        to_sample();
        chk("handoff T grant", a_grant, 2'b01);
        to_drive();
        to_sample();
        chk("handoff T+1 grant", a_grant, 2'b00);
        chk("handoff T+1 s_cyc", a_s_cyc, 0);
        to_drive();
        to_sample();
        chk("handoff T+2 grant", a_grant, 2'b10);
        chk("handoff T+2 s_addr", a_s_addr, 32'h0000_BAD0);
        to_drive();
        idle_inputs();

        // ---- arbitration ----
        run_masters(1'b0, 2, 2, 8'b10_01_10_01, 4, "rr");
        run_masters(1'b1, 1, 2, 8'b00_01_10_10, 3, "fixed");

        // ---- watchdog expiry on a dead address ----
        do_reset();
        manual = 1'b0; lat = 1; ack_k = -1; n_ack = 0;
        for (int k = 0; k < 15; k++) begin
            if (k == 0) begin
                m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_sel = 4'hF;
                m1_addr = c_dead_addr; m1_wdata = 32'h0123_4567;
                q1.push_back(c_to_data);
            end
            tclr = (k == 9) || (k == 12);
            to_sample();
            if (k == 8) begin
                chk("wd last wait s_cyc", a_s_cyc, 1);
                chk("wd last wait m1_ack", a_m1_ack, 0);
            end
            if (a_m1_ack) begin
                n_ack++;
                if (ack_k < 0) ack_k = k;
                exp = (q1.size() > 0) ? q1.pop_front() : 32'hFFFF_FFFF;
                chk("wd abort data", a_m1_rdata, exp);
                chk("wd abort s_cyc", a_s_cyc, 0);
                chk("wd abort s_stb", a_s_stb, 0);
                chk("wd abort s_addr", a_s_addr, 0);
                chk("wd abort m0_ack", a_m0_ack, 0);
            end
            if (k == 9)  chk("wd flag in abort", a_timeout, 0);
            if (k == 10) chk("wd flag set wins clear", a_timeout, 1);
            if (k == 12) chk("wd flag sticky", a_timeout, 1);
            if (k == 13) chk("wd flag cleared", a_timeout, 0);
            to_drive();
            if (n_ack > 0) idle_inputs();
        end
        chk("wd abort cycle", ack_k, 9);
        chk("wd abort ack count", n_ack, 1);

        // ---- ack arriving exactly in the expiry cycle ----
        lat = 7; ack_k = -1; n_ack = 0;
        for (int k = 0; k < 15; k++) begin
            if (k == 0) begin
                m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_sel = 4'hF;
                m1_addr = 32'h0000_8100;
                q1.push_back(ram_word(32'h0000_8100));
            end
            to_sample();
            if (a_m1_ack) begin
                n_ack++;
                if (ack_k < 0) ack_k = k;
                exp = (q1.size() > 0) ? q1.pop_front() : 32'hFFFF_FFFF;
                chk("late ack data", a_m1_rdata, exp);
                chk("late ack s_cyc", a_s_cyc, 1);
            end
            if (k == 14) chk("late ack flag", a_timeout, 0);
            to_drive();
            if (n_ack > 0) idle_inputs();
        end
        chk("late ack cycle", ack_k, 8);
        chk("late ack count", n_ack, 1);
        lat = 1;

        // ---- reset while m0 owns with a pending strobe ----
        m0_cyc = 1; m0_stb = 1; m0_addr = c_dead_addr; m0_sel = 4'hF;
        for (int k = 0; k < 6; k++) begin
            if (k == 3) rst = 1'b1;
            if (k == 4) rst = 1'b0;
            to_sample();
            if (k == 1) chk("rst-mid owner before", a_grant, 2'b01);
            if (k == 3) chk("rst-mid s_cyc in reset cycle", a_s_cyc, 1);
            if (k == 4) begin
                chk("rst-mid s_cyc after", a_s_cyc, 0);
                chk("rst-mid grant after", a_grant, 2'b00);
                chk("rst-mid m0_ack", a_m0_ack, 0);
                chk("rst-mid m1_ack", a_m1_ack, 0);
            end
            if (k == 5) begin
                chk("rst-mid regrant", a_grant, 2'b01);
                chk("rst-mid regrant s_cyc", a_s_cyc, 1);
            end
            to_drive();
        end
        idle_inputs();
        to_drive();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
